// File: rtl/hdmi_pkg.sv
// Shared definitions for the HDMI byte-stream pixel unpacker: start-of-frame
// marker bytes, framing FSM states and the packed RGB pixel layout.
package hdmi_pkg;

  localparam logic [7:0] SOF0_BYTE = 8'hAA;
  localparam logic [7:0] SOF1_BYTE = 8'h55;

  typedef enum logic [1:0] {
    SYNC0 = 2'd0,
    SYNC1 = 2'd1,
    PIX   = 2'd2
  } state_e;

  // R occupies the top byte because it is the first byte of each triplet.
  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pixel_t;

endpackage

// File: rtl/hdmi_pixel_unpacker.sv
// Pops bytes from a standard (non-FWFT) HDMI byte FIFO, locks onto a 2-byte
// start-of-frame marker, packs RGB triplets into 24-bit pixels with a linear
// frame-buffer address and presents them on a valid/ready port.
module hdmi_pixel_unpacker
  import hdmi_pkg::*;
#(
  parameter int         H_RES  = 640,
  parameter int         V_RES  = 480,
  parameter int         ADDR_W = 19,
  parameter logic [7:0] SOF0   = SOF0_BYTE,
  parameter logic [7:0] SOF1   = SOF1_BYTE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              src_switch,
  input  logic              hdmi_fifo_empty,
  input  logic [7:0]        hdmi_fifo_data,
  output logic              hdmi_fifo_rd_en,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic [23:0]       pix_data,
  output logic [ADDR_W-1:0] pix_addr,
  output logic              frame_done,
  output logic              sync_err
);

  localparam int                NUM_PIX   = H_RES * V_RES;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIX - 1);

  state_e            state_q;
  logic [1:0]        byte_cnt_q;
  logic [7:0]        r_q;
  logic [7:0]        g_q;
  logic [ADDR_W-1:0] asm_addr_q;   // address of the pixel being assembled
  pixel_t            pix_q;
  logic [ADDR_W-1:0] pix_addr_q;   // address of the pixel being presented
  logic              pix_valid_q;
  logic              sync_err_q;
  logic              rd_q;         // a byte requested last cycle is on hdmi_fifo_data now

  logic handshake;
  logic hold;

  // Read request, handshake and end-of-frame decode.
  // NOTE: every signal driven here is assigned on every path, so no latch is inferred.
  always_comb begin
    handshake = pix_valid_q & pix_ready;
    // A stalled output pixel blocks new requests; at most one byte is then in
    // flight, and it can never be a B byte, so the held pixel is never overwritten.
    hold      = (pix_valid_q & ~pix_ready) |
                (rd_q & (byte_cnt_q == 2'd2) & (state_q == PIX) & pix_valid_q & ~pix_ready);
    // Gating with rst keeps the pop request low for the whole reset interval.
    hdmi_fifo_rd_en = ~rst & ~hdmi_fifo_empty & ~hold & ~src_switch;
    frame_done      = handshake & (pix_addr_q == LAST_ADDR);
  end

  // Track which cycle carries read data (one cycle after the request).
  // NOTE: sequential state is always updated with non-blocking assignments.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q <= 1'b0;
    end else begin
      rd_q <= hdmi_fifo_rd_en;
    end
  end

  // Framing FSM, pixel assembly and registered output port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= SYNC0;
      byte_cnt_q  <= 2'd0;
      r_q         <= 8'd0;
      g_q         <= 8'd0;
      asm_addr_q  <= '0;
      pix_q       <= '0;
      pix_addr_q  <= '0;
      pix_valid_q <= 1'b0;
      sync_err_q  <= 1'b0;
    end else begin
      sync_err_q <= 1'b0;

      if (handshake) begin
        pix_valid_q <= 1'b0;
      end

      if (src_switch) begin
        // Drop the partial pixel and any byte landing this cycle; a pending
        // output pixel stays on the port until it is accepted.
        state_q    <= SYNC0;
        byte_cnt_q <= 2'd0;
        asm_addr_q <= '0;
      end else if (rd_q) begin
        unique case (state_q)
          SYNC0: begin
            if (hdmi_fifo_data == SOF0) state_q <= SYNC1;
          end
          SYNC1: begin
            if (hdmi_fifo_data == SOF1) begin
              state_q    <= PIX;
              byte_cnt_q <= 2'd0;
              asm_addr_q <= '0;
            end else if (hdmi_fifo_data != SOF0) begin
              state_q    <= SYNC0;
              sync_err_q <= 1'b1;
            end
          end
          PIX: begin
            unique case (byte_cnt_q)
              2'd0: begin
                r_q        <= hdmi_fifo_data;
                byte_cnt_q <= 2'd1;
              end
              2'd1: begin
                g_q        <= hdmi_fifo_data;
                byte_cnt_q <= 2'd2;
              end
              default: begin
                pix_q       <= '{r: r_q, g: g_q, b: hdmi_fifo_data};
                pix_addr_q  <= asm_addr_q;
                pix_valid_q <= 1'b1;
                byte_cnt_q  <= 2'd0;
                // Leave PIX as soon as the last pixel is assembled so the bytes
                // that follow are parsed as the next frame's marker.
                if (asm_addr_q == LAST_ADDR) begin
                  asm_addr_q <= '0;
                  state_q    <= SYNC0;
                end else begin
                  asm_addr_q <= asm_addr_q + 1'b1;
                end
              end
            endcase
          end
          default: state_q <= SYNC0;
        endcase
      end
    end
  end

  assign pix_valid = pix_valid_q;
  assign pix_data  = pix_q;
  assign pix_addr  = pix_addr_q;
  assign sync_err  = sync_err_q;

endmodule

// File: tb/tb_hdmi_pixel_unpacker.sv
// Self-checking bench for hdmi_pixel_unpacker: a queue-backed FIFO model,
// a byte-stream framing model producing expected pixels, and per-scenario tasks.
module tb_hdmi_pixel_unpacker;

  localparam int H_RES  = 4;
  localparam int V_RES  = 2;
  localparam int ADDR_W = 3;
  localparam int NPIX   = H_RES * V_RES;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              src_switch = 1'b0;
  logic              hdmi_fifo_empty = 1'b1;
  logic [7:0]        hdmi_fifo_data = 8'h00;
  logic              hdmi_fifo_rd_en;
  logic              pix_valid;
  logic              pix_ready = 1'b0;
  logic [23:0]       pix_data;
  logic [ADDR_W-1:0] pix_addr;
  logic              frame_done;
  logic              sync_err;

  hdmi_pixel_unpacker #(.H_RES(H_RES), .V_RES(V_RES), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .src_switch(src_switch),
    .hdmi_fifo_empty(hdmi_fifo_empty), .hdmi_fifo_data(hdmi_fifo_data),
    .hdmi_fifo_rd_en(hdmi_fifo_rd_en), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_data(pix_data), .pix_addr(pix_addr), .frame_done(frame_done), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0]       data;
    logic [ADDR_W-1:0] addr;
    logic              fd;
    int                cyc;
  } px_t;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] fifo_q[$];
  px_t        exp_q[$];
  px_t        obs_q[$];

  bit gate_empty = 1'b1;
  bit rand_empty = 1'b0;
  bit rand_ready = 1'b0;
  int stall_left = 0;
  int cyc = 0;
  int viol_rd = 0, viol_stab = 0, stray_fd = 0, err_obs = 0;
  bit last_rd_en = 1'b0;
  bit prev_stall = 1'b0;
  logic [23:0]       prev_data = '0;
  logic [ADDR_W-1:0] prev_addr = '0;

  // Framing model: 0 = hunting first marker, 1 = after first marker, 2 = in pixels.
  int          m_state = 0, m_cnt = 0, m_addr = 0, m_err = 0;
  logic [23:0] m_acc = '0;

  function automatic void model_byte(input logic [7:0] b);
    px_t e;
    case (m_state)
      0: if (b == 8'hAA) m_state = 1;
      1: begin
        if (b == 8'h55) begin
          m_state = 2; m_cnt = 0; m_addr = 0;
        end else if (b != 8'hAA) begin
          m_state = 0; m_err++;
        end
      end
      default: begin
        m_acc = {m_acc[15:0], b};
        m_cnt++;
        if (m_cnt == 3) begin
          e.data = m_acc; e.addr = ADDR_W'(m_addr); e.fd = (m_addr == NPIX - 1); e.cyc = 0;
          exp_q.push_back(e);
          m_cnt = 0;
          m_addr++;
          if (m_addr == NPIX) begin
            m_addr = 0; m_state = 0;
          end
        end
      end
    endcase
  endfunction

  task automatic push_byte(input logic [7:0] b);
    fifo_q.push_back(b);
    model_byte(b);
  endtask

  task automatic update_empty();
    hdmi_fifo_empty = gate_empty || (fifo_q.size() == 0);
  endtask

  // One clock: observe at the falling edge, then drive the FIFO model 1 ns after the rising edge.
  task automatic step();
    px_t o;
    @(negedge clk);
    last_rd_en = hdmi_fifo_rd_en;
    if (hdmi_fifo_rd_en && hdmi_fifo_empty) viol_rd++;
    if (prev_stall && (pix_valid !== 1'b1 || pix_data !== prev_data || pix_addr !== prev_addr)) viol_stab++;
    if (frame_done && !(pix_valid && pix_ready)) stray_fd++;
    if (sync_err) err_obs++;
    if (pix_valid && pix_ready) begin
      o.data = pix_data; o.addr = pix_addr; o.fd = frame_done; o.cyc = cyc;
      obs_q.push_back(o);
    end
    prev_stall = pix_valid && !pix_ready;
    prev_data  = pix_data;
    prev_addr  = pix_addr;
    @(posedge clk);
    cyc++;
    #1;
    if (last_rd_en && fifo_q.size() > 0) hdmi_fifo_data = fifo_q.pop_front();
    if (rand_empty) gate_empty = ($urandom_range(0, 3) == 0);
    if (stall_left > 0) begin
      pix_ready = 1'b0;
      stall_left--;
    end else if (rand_ready) begin
      pix_ready = ($urandom_range(0, 3) != 0);
    end
    update_empty();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic apply_reset();
    rst = 1'b1; src_switch = 1'b0; pix_ready = 1'b0;
    gate_empty = 1'b1; rand_empty = 1'b0; rand_ready = 1'b0; stall_left = 0;
    fifo_q.delete(); exp_q.delete(); obs_q.delete();
    viol_rd = 0; viol_stab = 0; stray_fd = 0; err_obs = 0; prev_stall = 1'b0;
    m_state = 0; m_cnt = 0; m_addr = 0; m_err = 0; m_acc = '0;
    update_empty();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    n_tests++;
    if (pix_valid !== 1'b0 || frame_done !== 1'b0 || sync_err !== 1'b0) begin
      n_fail++; $display("FAIL reset_flags: valid=%b fd=%b err=%b, expected 0 0 0", pix_valid, frame_done, sync_err);
    end
    n_tests++;
    if (pix_data !== 24'h0 || pix_addr !== '0) begin
      n_fail++; $display("FAIL reset_data: data=%h addr=%0d, expected 0 0", pix_data, pix_addr);
    end
    hdmi_fifo_empty = 1'b0;
    #1;
    n_tests++;
    if (hdmi_fifo_rd_en !== 1'b0) begin
      n_fail++; $display("FAIL reset_rd_en: rd_en=%b with FIFO non-empty in reset, expected 0", hdmi_fifo_rd_en);
    end
  endtask

  task automatic test_basic();
    logic [7:0]  s [8] = '{8'hAA, 8'h55, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    logic [13:0] hist = '0;
    int c0;
    apply_reset();
    pix_ready = 1'b1;
    foreach (s[i]) push_byte(s[i]);
    gate_empty = 1'b0;
    update_empty();
    c0 = cyc;
    for (int i = 0; i < 14; i++) begin
      step();
      hist[i] = last_rd_en;
    end
    n_tests++;
    if (hist !== 14'h00FF) begin
      n_fail++; $display("FAIL basic_rd_en: trace %b, expected %b", hist, 14'h00FF);
    end
    n_tests++;
    if (obs_q.size() != 2) begin
      n_fail++; $display("FAIL basic_count: got %0d pixels, expected 2", obs_q.size());
    end else begin
      n_tests++;
      if (obs_q[0].data !== 24'h010203 || obs_q[0].addr !== 3'd0 || obs_q[1].data !== 24'h040506 || obs_q[1].addr !== 3'd1) begin
        n_fail++; $display("FAIL basic_pix: got %h@%0d %h@%0d, expected 010203@0 040506@1",
                           obs_q[0].data, obs_q[0].addr, obs_q[1].data, obs_q[1].addr);
      end
      n_tests++;
      if (obs_q[0].cyc - c0 != 6 || obs_q[1].cyc - c0 != 9) begin
        n_fail++; $display("FAIL basic_latency: valid at +%0d/+%0d, expected +6/+9", obs_q[0].cyc - c0, obs_q[1].cyc - c0);
      end
    end
  endtask

  task automatic test_sync_err();
    logic [7:0] s [10] = '{8'h12, 8'h34, 8'hAA, 8'h77, 8'hAA, 8'hAA, 8'h55, 8'hA1, 8'hB2, 8'hC3};
    apply_reset();
    pix_ready = 1'b1;
    foreach (s[i]) push_byte(s[i]);
    gate_empty = 1'b0;
    update_empty();
    run(20);
    n_tests++;
    if (err_obs != m_err || err_obs != 1) begin
      n_fail++; $display("FAIL syncerr_count: got %0d pulses, expected %0d", err_obs, m_err);
    end
    n_tests++;
    if (obs_q.size() != 1 || exp_q.size() != 1) begin
      n_fail++; $display("FAIL syncerr_npix: got %0d pixels, expected %0d", obs_q.size(), exp_q.size());
    end else begin
      n_tests++;
      if (obs_q[0].data !== exp_q[0].data || obs_q[0].addr !== exp_q[0].addr) begin
        n_fail++; $display("FAIL syncerr_pix: got %h@%0d, expected %h@%0d", obs_q[0].data, obs_q[0].addr, exp_q[0].data, exp_q[0].addr);
      end
    end
  endtask

  task automatic test_stall_random();
    bit stalled = 1'b0;
    apply_reset();
    for (int i = 0; i < 4; i++) push_byte(8'($urandom_range(0, 8'hA9)));
    push_byte(8'hAA); push_byte(8'h55);
    for (int i = 0; i < 3 * NPIX; i++) push_byte(8'($urandom));
    push_byte(8'hAA); push_byte(8'h55);
    for (int i = 0; i < 6; i++) push_byte(8'($urandom));
    rand_empty = 1'b1; rand_ready = 1'b1;
    for (int i = 0; i < 250; i++) begin
      step();
      if (!stalled && obs_q.size() >= 2) begin
        stall_left = 5; stalled = 1'b1;
      end
    end
    rand_empty = 1'b0; rand_ready = 1'b0; gate_empty = 1'b0; pix_ready = 1'b1;
    update_empty();
    run(20);
    n_tests++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL stall_count: got %0d pixels, expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_tests++;
      if (obs_q[i].data !== exp_q[i].data || obs_q[i].addr !== exp_q[i].addr || obs_q[i].fd !== exp_q[i].fd) begin
        n_fail++; $display("FAIL stall_pix%0d: got %h@%0d fd=%b, expected %h@%0d fd=%b", i,
                           obs_q[i].data, obs_q[i].addr, obs_q[i].fd, exp_q[i].data, exp_q[i].addr, exp_q[i].fd);
      end
    end
    n_tests++;
    if (viol_stab != 0 || viol_rd != 0 || stray_fd != 0) begin
      n_fail++; $display("FAIL stall_protocol: unstable=%0d rd_when_empty=%0d stray_fd=%0d, expected 0 0 0", viol_stab, viol_rd, stray_fd);
    end
    n_tests++;
    if (err_obs != m_err) begin
      n_fail++; $display("FAIL stall_syncerr: got %0d, expected %0d", err_obs, m_err);
    end
  endtask

  task automatic test_back_to_back();
    int nfd = 0;
    apply_reset();
    pix_ready = 1'b1;
    push_byte(8'hAA); push_byte(8'h55);
    for (int i = 0; i < 3 * NPIX; i++) push_byte(8'($urandom));
    push_byte(8'h01); push_byte(8'h02); push_byte(8'h03);
    push_byte(8'hAA); push_byte(8'h55);
    for (int i = 0; i < 3 * NPIX; i++) push_byte(8'($urandom));
    gate_empty = 1'b0;
    update_empty();
    run(80);
    n_tests++;
    if (obs_q.size() != exp_q.size() || obs_q.size() != 2 * NPIX) begin
      n_fail++; $display("FAIL b2b_count: got %0d pixels, expected %0d", obs_q.size(), 2 * NPIX);
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      if (obs_q[i].fd) nfd++;
      n_tests++;
      if (obs_q[i].data !== exp_q[i].data || obs_q[i].addr !== exp_q[i].addr || obs_q[i].fd !== exp_q[i].fd) begin
        n_fail++; $display("FAIL b2b_pix%0d: got %h@%0d fd=%b, expected %h@%0d fd=%b", i,
                           obs_q[i].data, obs_q[i].addr, obs_q[i].fd, exp_q[i].data, exp_q[i].addr, exp_q[i].fd);
      end
    end
    n_tests++;
    if (nfd != 2 || stray_fd != 0) begin
      n_fail++; $display("FAIL b2b_frame_done: got %0d pulses (%0d stray), expected 2 (0 stray)", nfd, stray_fd);
    end
  endtask

  task automatic test_src_switch();
    apply_reset();
    pix_ready = 1'b1;
    push_byte(8'hAA); push_byte(8'h55); push_byte(8'h11); push_byte(8'h22);
    gate_empty = 1'b0;
    update_empty();
    run(10);
    src_switch = 1'b1;
    m_state = 0; m_cnt = 0; m_addr = 0;
    push_byte(8'hAA); push_byte(8'h55); push_byte(8'h33); push_byte(8'h44); push_byte(8'h55);
    update_empty();
    step();
    n_tests++;
    if (last_rd_en !== 1'b0) begin
      n_fail++; $display("FAIL switch_rd_en: rd_en=%b in switch cycle, expected 0", last_rd_en);
    end
    src_switch = 1'b0;
    run(15);
    n_tests++;
    if (obs_q.size() != 1 || exp_q.size() != 1) begin
      n_fail++; $display("FAIL switch_count: got %0d pixels, expected 1", obs_q.size());
    end else begin
      n_tests++;
      if (obs_q[0].data !== 24'h334455 || obs_q[0].addr !== 3'd0 || obs_q[0].data !== exp_q[0].data) begin
        n_fail++; $display("FAIL switch_pix: got %h@%0d, expected 334455@0", obs_q[0].data, obs_q[0].addr);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    apply_reset();
    push_byte(8'hAA); push_byte(8'h55);
    for (int i = 0; i < 3 * NPIX; i++) push_byte(8'($urandom));
    rand_empty = 1'b1; rand_ready = 1'b1;
    run(6);
    for (int i = 0; i < 80 && pix_valid !== 1'b1; i++) step();
    n_tests++;
    if (pix_valid !== 1'b1 || viol_rd != 0) begin
      n_fail++; $display("FAIL midrst_pre: valid=%b rd_when_empty=%0d before reset, expected 1 0", pix_valid, viol_rd);
    end
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if (pix_valid !== 1'b0 || pix_data !== 24'h0 || pix_addr !== '0 || frame_done !== 1'b0 || sync_err !== 1'b0) begin
      n_fail++; $display("FAIL midrst_async: valid=%b data=%h addr=%0d fd=%b err=%b, expected all 0",
                         pix_valid, pix_data, pix_addr, frame_done, sync_err);
    end
    for (int i = 0; i < 4; i++) begin
      hdmi_fifo_empty = ~hdmi_fifo_empty;
      #1;
      n_tests++;
      if (hdmi_fifo_rd_en !== 1'b0) begin
        n_fail++; $display("FAIL midrst_rd_en%0d: rd_en=%b empty=%b in reset, expected 0", i, hdmi_fifo_rd_en, hdmi_fifo_empty);
      end
    end
    apply_reset();
    pix_ready = 1'b1;
    push_byte(8'h01); push_byte(8'h02); push_byte(8'h03);
    push_byte(8'hAA); push_byte(8'h55);
    push_byte(8'hD1); push_byte(8'hD2); push_byte(8'hD3);
    gate_empty = 1'b0;
    update_empty();
    run(20);
    n_tests++;
    if (obs_q.size() != 1 || obs_q[0].data !== 24'hD1D2D3 || obs_q[0].addr !== 3'd0) begin
      n_fail++; $display("FAIL midrst_restart: got %0d pixels (first %h@%0d), expected 1 pixel D1D2D3@0",
                         obs_q.size(), obs_q.size() > 0 ? obs_q[0].data : 24'h0, obs_q.size() > 0 ? obs_q[0].addr : 3'd0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sync_err();
    test_stall_random();
    test_back_to_back();
    test_src_switch();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded 200000 ns");
    $fatal(1, "timeout");
  end

endmodule
